// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: circular buffer plus a three-state send FSM that
// issues one start pulse per frame and recovers if the UART never acknowledges the pulse.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_byte,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StWaitStart = 2'd1;
  localparam logic [1:0] StWaitDone  = 2'd2;
  localparam logic [1:0] WAIT_LIMIT  = 2'd3;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_d;
  logic                  r_full;
  logic                  r_overflow;
  logic [1:0]            r_state;
  logic [1:0]            w_state_d;
  logic [1:0]            r_wait;
  logic [7:0]            r_tx_byte;
  logic                  w_push_ok;
  logic                  w_pop;

  // Push is judged against the registered full flag, so a same-cycle pop never rescues it.
  assign w_push_ok = push & ~r_full;
  assign w_pop     = (r_state == StIdle) & (r_count != '0) & ~is_transmitting & ~rst;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push_ok, w_pop})
      2'b10:   w_count_d = r_count + CNT_ONE;
      2'b01:   w_count_d = r_count - CNT_ONE;
      default: w_count_d = r_count;
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_pop) w_state_d = StWaitStart;
      end
      StWaitStart: begin
        // A UART that never raises busy still consumes the byte after the timeout.
        if (is_transmitting)           w_state_d = StWaitDone;
        else if (r_wait == WAIT_LIMIT) w_state_d = StIdle;
      end
      StWaitDone: begin
        if (!is_transmitting) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) r_mem[r_wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_state    <= StIdle;
      r_wait     <= '0;
      r_tx_byte  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_tx_byte <= r_mem[r_rd_ptr];
      end
      if (push && r_full) r_overflow <= 1'b1;
      r_count <= w_count_d;
      r_full  <= (w_count_d == CNT_FULL);
      r_state <= w_state_d;
      if (r_state == StWaitStart && !is_transmitting) r_wait <= r_wait + 2'd1;
      else                                            r_wait <= '0;
    end
  end

  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign transmit = w_pop;
  // Head byte is visible during the pulse cycle, then held until the next pulse.
  assign tx_byte  = w_pop ? r_mem[r_rd_ptr] : r_tx_byte;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a small UART busy model plus an in-order byte scoreboard.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_byte;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  uart_tx_fifo dut (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .push_byte       (push_byte),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .is_transmitting (is_transmitting),
    .transmit        (transmit),
    .tx_byte         (tx_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int busy_left = 0;
  int busy_len = 10;
  int uart_mode = 0;  // 0: busy model, 1: forced busy, 2: never busy
  int pulses = 0;
  int dbl = 0;
  int sb_err = 0;
  int cnt_err = 0;
  int max_count = 0;
  int m_count = 0;
  int cyc = 0;
  bit need_busy = 0;
  bit model_valid = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  int pulse_cyc[$];

  // One clock cycle: drive inputs, sample just after, update models, then cross the edge.
  task automatic cycle(input logic p, input logic [7:0] b);
    logic tx_seen;
    logic acc;
    push = p;
    push_byte = b;
    if (uart_mode == 0) is_transmitting = (busy_left > 0);
    else is_transmitting = (uart_mode == 1);
    #1;
    tx_seen = transmit;
    if (int'(count) > max_count) max_count = int'(count);
    if (model_valid && count !== 5'(m_count)) cnt_err++;
    if (rst) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      acc = p && (m_count < 16);
      if (tx_seen) begin
        pulses++;
        pulse_cyc.push_back(cyc);
        sent_q.push_back(tx_byte);
        if (need_busy && uart_mode == 0) dbl++;
        need_busy = 1;
        if (exp_q.size() == 0) sb_err++;
        else begin
          if (exp_q[0] !== tx_byte) sb_err++;
          void'(exp_q.pop_front());
        end
      end
      if (acc) exp_q.push_back(b);
      m_count = m_count + int'(acc) - int'(tx_seen);
    end
    if (is_transmitting) need_busy = 0;
    @(posedge clk);
    #2;
    cyc++;
    if (tx_seen) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
  endtask

  task automatic clear_stats();
    pulses = 0; dbl = 0; sb_err = 0; cnt_err = 0; max_count = 0; need_busy = 0;
    sent_q.delete();
    pulse_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h55);
    rst = 1'b0;
    model_valid = 1;
    push = 1'b0;
    is_transmitting = 1'b0;
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL reset_transmit: got %b expected 0", transmit); end
    n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
  endtask

  task automatic test_single();
    clear_stats();
    uart_mode = 0; busy_len = 10; busy_left = 0;
    push = 1'b1; push_byte = 8'h41; is_transmitting = 1'b0;
    #1;
    n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_no_early_tx: got %b expected 0", transmit); end
    cycle(1'b1, 8'h41);
    push = 1'b0;
    #1;
    n_checks++; if (transmit !== 1'b1) begin n_fail++; $display("FAIL single_tx_pulse: got %b expected 1", transmit); end
    n_checks++; if (tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_tx_byte: got %h expected 41", tx_byte); end
    n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count_pre: got %0d expected 1", count); end
    cycle(1'b0, 8'h00);
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL single_count_post: got %0d expected 0", count); end
    n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b expected 0", transmit); end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    n_checks++; if (tx_byte !== 8'h41) begin n_fail++; $display("FAIL single_tx_hold: got %h expected 41", tx_byte); end
  endtask

  task automatic test_fill();
    uart_mode = 1;
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i));
    push = 1'b0; is_transmitting = 1'b1;
    #1;
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b expected 1", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b expected 0", overflow); end
    cycle(1'b1, 8'h11);
    push = 1'b0;
    #1;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_set: got %b expected 1", overflow); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_ovf_count: got %0d expected 16", count); end
  endtask

  task automatic test_drain();
    clear_stats();
    uart_mode = 0; busy_len = 10; busy_left = 0;
    for (int i = 0; i < 16 * 12 + 20; i++) cycle(1'b0, 8'h00);
    n_checks++; if (pulses !== 16) begin n_fail++; $display("FAIL drain_pulses: got %0d expected 16", pulses); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= sent_q.size()) begin
        n_fail++; $display("FAIL drain_order[%0d]: got nothing expected %h", i, 8'(i + 1));
      end else if (sent_q[i] !== 8'(i + 1)) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %h expected %h", i, sent_q[i], 8'(i + 1));
      end
    end
    n_checks++; if (dbl !== 0) begin n_fail++; $display("FAIL drain_one_per_frame: got %0d extra expected 0", dbl); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL drain_full: got %b expected 0", full); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drain_ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_wrap();
    clear_stats();
    uart_mode = 0; busy_len = 1; busy_left = 0;
    for (int i = 0; i < 90; i++) cycle(1'b1, 8'(i + 8'h80));
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00);
    n_checks++; if (sb_err !== 0) begin n_fail++; $display("FAIL wrap_order: got %0d bad bytes expected 0", sb_err); end
    n_checks++; if (cnt_err !== 0) begin n_fail++; $display("FAIL wrap_count_track: got %0d diffs expected 0", cnt_err); end
    n_checks++; if (max_count !== 16) begin n_fail++; $display("FAIL wrap_max_count: got %0d expected 16", max_count); end
    n_checks++; if (pulses < 40) begin n_fail++; $display("FAIL wrap_sent: got %0d expected >=40", pulses); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL wrap_residue: got %0d unsent expected 0", exp_q.size()); end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL wrap_count: got %0d expected 0", count); end
  endtask

  task automatic test_timeout();
    clear_stats();
    uart_mode = 2; busy_left = 0;
    cycle(1'b1, 8'hA1);
    cycle(1'b1, 8'hA2);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00);
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 2", pulses); end
    if (pulses == 2) begin
      n_checks++; if (sent_q[0] !== 8'hA1) begin n_fail++; $display("FAIL timeout_byte0: got %h expected a1", sent_q[0]); end
      n_checks++; if (sent_q[1] !== 8'hA2) begin n_fail++; $display("FAIL timeout_byte1: got %h expected a2", sent_q[1]); end
      n_checks++;
      if (pulse_cyc[1] - pulse_cyc[0] !== 5) begin
        n_fail++; $display("FAIL timeout_gap: got %0d expected 5", pulse_cyc[1] - pulse_cyc[0]);
      end
    end
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL timeout_count: got %0d expected 0", count); end
  endtask

  task automatic test_reset_midframe();
    clear_stats();
    uart_mode = 0; busy_len = 10; busy_left = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hB0 + i));
    push = 1'b0; is_transmitting = (busy_left > 0);
    #1;
    n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL midframe_queued: got %0d expected 5", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL midframe_ovf_pre: got %b expected 1", overflow); end
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    rst = 1'b0;
    push = 1'b0; is_transmitting = (busy_left > 0);
    #1;
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL midframe_count: got %0d expected 0", count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midframe_ovf: got %b expected 0", overflow); end
    n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL midframe_tx: got %b expected 0", transmit); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL midframe_full: got %b expected 0", full); end
    for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00);
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL midframe_silent: got %0d pulses expected 1", pulses); end
    cycle(1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL midframe_resume: got %0d pulses expected 2", pulses); end
    if (pulses == 2) begin
      n_checks++; if (sent_q[1] !== 8'hC3) begin n_fail++; $display("FAIL midframe_byte: got %h expected c3", sent_q[1]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    push = 1'b0;
    push_byte = 8'h00;
    is_transmitting = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_wrap();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
